// File: rtl/output_deskew_fifo.sv
`default_nettype none
// ============================================================================
// Module      : output_deskew_fifo
// Description : Realigns staggered systolic-array lanes and buffers the rows
//               in a drop-on-full FIFO. Define OUTPUT_DESKEW_RELU_EN to zero
//               negative lanes on the write path.
// Revision    : 1.0 - initial release
// ============================================================================
module output_deskew_fifo #(
    parameter int ABITS = 16,
    parameter int N     = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*ABITS-1:0]     accum_in_vector,
    input  logic                   in_valid,
    output logic [N*ABITS-1:0]     out_vector,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [N*ABITS-1:0] w_aligned;
    logic [N*ABITS-1:0] w_wr_data;
    logic               w_wr_en;

    // Lane j arrives j cycles after lane 0, so it needs N-1-j stages to line up.
    generate
        for (genvar j = 0; j < N; j++) begin : g_lane
            localparam int c_dly = N - 1 - j;
            if (c_dly == 0) begin : g_direct
                assign w_aligned[j*ABITS +: ABITS] = accum_in_vector[j*ABITS +: ABITS];
            end else begin : g_delay
                logic [ABITS-1:0] r_dly [c_dly];
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int k = 0; k < c_dly; k++) r_dly[k] <= '0;
                    end else begin
                        r_dly[0] <= accum_in_vector[j*ABITS +: ABITS];
                        for (int k = 1; k < c_dly; k++) r_dly[k] <= r_dly[k-1];
                    end
                end
                assign w_aligned[j*ABITS +: ABITS] = r_dly[c_dly-1];
            end
        end
    endgenerate

    generate
        if (N == 1) begin : g_vld_direct
            assign w_wr_en = in_valid;
        end else begin : g_vld_pipe
            logic [N-2:0] r_vld;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= in_valid;
                    for (int k = 1; k < N - 1; k++) r_vld[k] <= r_vld[k-1];
                end
            end
            assign w_wr_en = r_vld[N-2];
        end
    endgenerate

    generate
        for (genvar j = 0; j < N; j++) begin : g_wr_data
`ifdef OUTPUT_DESKEW_RELU_EN
            assign w_wr_data[j*ABITS +: ABITS] = w_aligned[j*ABITS + ABITS - 1]
                                               ? '0 : w_aligned[j*ABITS +: ABITS];
`else
            assign w_wr_data[j*ABITS +: ABITS] = w_aligned[j*ABITS +: ABITS];
`endif
        end
    endgenerate

    logic [N*ABITS-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the row.
    assign w_full = (r_count == c_depth);
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_wr_en & (~w_full | w_pop);
    assign w_drop = w_wr_en & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_vector = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_deskew_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_deskew_fifo
// Description : Scoreboard bench for output_deskew_fifo (N=2, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_deskew_fifo;

    localparam int ABITS = 16;
    localparam int N     = 2;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N*ABITS-1:0]   accum_in_vector;
    logic                 in_valid;
    logic [N*ABITS-1:0]   out_vector;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           count;
    logic                 overflow;
    logic                 clear_overflow;

    output_deskew_fifo #(.ABITS(ABITS), .N(N), .DEPTH(DEPTH)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .accum_in_vector (accum_in_vector),
        .in_valid        (in_valid),
        .out_vector      (out_vector),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .count           (count),
        .overflow        (overflow),
        .clear_overflow  (clear_overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        exp_ovf;
    logic        s1_v;
    logic [15:0] s1_l0;
    logic [15:0] prev_l1;
    logic        mon_en;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef OUTPUT_DESKEW_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    // Lane 1 of a row is presented one cycle after its lane 0.
    task automatic drive(input logic v, input logic [15:0] l0, input logic [15:0] l1,
                         input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        in_valid        = v;
        accum_in_vector = {prev_l1, v ? l0 : 16'h0000};
        out_ready       = rdy;
        clear_overflow  = clr;
        prev_l1         = v ? l1 : 16'h0000;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, rdy, 1'b0);
    endtask

    // Reference FIFO: a row is written one cycle after its in_valid cycle.
    initial begin
        logic        m_pop;
        logic        m_drop;
        logic [31:0] m_row;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("count", 32'(count), 32'(exp_q.size()));
                check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                check("overflow", 32'(overflow), 32'(exp_ovf));
                if (exp_q.size() != 0) check("head", out_vector, exp_q[0]);
                m_pop = (exp_q.size() != 0) && out_ready;
                if (m_pop) void'(exp_q.pop_front());
                m_drop = 1'b0;
                if (s1_v) begin
                    m_row = {relu(accum_in_vector[31:16]), relu(s1_l0)};
                    if (exp_q.size() < DEPTH) exp_q.push_back(m_row);
                    else m_drop = 1'b1;
                end
                if (m_drop) exp_ovf = 1'b1;
                else if (clear_overflow) exp_ovf = 1'b0;
                s1_v  = in_valid;
                s1_l0 = accum_in_vector[15:0];
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        s1_v    = 1'b0;
        s1_l0   = 16'h0;
        prev_l1 = 16'h0;
    endtask

    initial begin
        mon_en          = 1'b0;
        reset           = 1'b1;
        in_valid        = 1'b0;
        accum_in_vector = '0;
        out_ready       = 1'b0;
        clear_overflow  = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        // Single row latency and deskew
        drive(1'b1, 16'h0011, 16'h0022, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Five back-to-back rows with consumer stalled: fifth dropped
        for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 16'(16'h0100 + i), 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Full FIFO with write and pop in the same cycle, pointers wrap
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h0010 + i), 16'(16'h0A10 + i), 1'b0, 1'b0);
        drive(1'b1, 16'h0020, 16'h0A20, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) drive(1'b1, 16'(16'h0020 + i), 16'(16'h0A20 + i), 1'b1, 1'b0);
        idle(6, 1'b1);

        // ReLU sensitive row
        drive(1'b1, 16'hFFF0, 16'h0005, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Clear in the same cycle as a drop: set wins
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h0030 + i), 16'(16'h8030 + i), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(2, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Random traffic
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        idle(6, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Reset mid-stream with a full FIFO, overflow set and a row in flight
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h0040 + i), 16'(16'h0140 + i), 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b1, 16'h0077, 16'h0088, 1'b0, 1'b0);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        in_valid        = 1'b0;
        accum_in_vector = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        idle(4, 1'b1);
        drive(1'b1, 16'h0123, 16'h0456, 1'b1, 1'b0);
        idle(4, 1'b1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
